// File: rtl/axi_mem_responder.sv
// Byte-addressed AXI4-Lite-style memory responder with programmable read/write latency,
// SLVERR on out-of-range accesses and a backdoor byte port for preload and readback.
module axi_mem_responder #(
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned READ_LAT  = 4,
    parameter int unsigned WRITE_LAT = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     ARVALID,
    input  logic [31:0]              ARADDR,
    output logic                     ARREADY,
    output logic                     RVALID,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    input  logic                     RREADY,
    input  logic                     AWVALID,
    input  logic [31:0]              AWADDR,
    output logic                     AWREADY,
    input  logic                     WVALID,
    input  logic [31:0]              WDATA,
    output logic                     WREADY,
    output logic                     BVALID,
    output logic [1:0]               BRESP,
    input  logic                     BREADY,
    input  logic                     bd_we,
    input  logic [$clog2(DEPTH)-1:0] bd_addr,
    input  logic [7:0]               bd_wdata,
    output logic [7:0]               bd_rdata
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [3:0]  RLoad   = 4'(READ_LAT - 1);
    localparam logic [3:0]  WLoad   = 4'(WRITE_LAT - 1);
    localparam logic [1:0]  RespOk  = 2'b00;
    localparam logic [1:0]  RespErr = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    logic [7:0] mem [DEPTH];

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_data_q, w_data_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        w_commit;
    logic        w_in_range;

    logic [31:0] rd_word;
    logic [32:0] lane_addr;
    logic        unused_wdata;

    assign unused_wdata = ^WDATA[31:8];

    // READY is masked while reset is asserted so it only rises once reset is released.
    assign ARREADY  = (r_state_q == R_IDLE) && !ARESET;
    assign AWREADY  = (w_state_q == W_IDLE) && !aw_held_q && !ARESET;
    assign WREADY   = (w_state_q == W_IDLE) && !w_held_q && !ARESET;
    assign RVALID   = (r_state_q == R_RESP);
    assign BVALID   = (w_state_q == W_RESP);
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign BRESP    = bresp_q;
    assign bd_rdata = mem[bd_addr];

    assign w_in_range = (w_addr_q < DEPTH);

    // Little-endian gather; lanes past the end read as zero (33-bit sum so nothing wraps).
    always_comb begin
        rd_word   = '0;
        lane_addr = '0;
        for (int i = 0; i < 4; i++) begin
            lane_addr = {1'b0, r_addr_q} + 33'(i);
            if (lane_addr < 33'(DEPTH)) begin
                rd_word[8*i +: 8] = mem[lane_addr[AW-1:0]];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_addr_d  = r_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    r_addr_d  = ARADDR;
                    r_cnt_d   = RLoad;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    rdata_d   = rd_word;
                    rresp_d   = (r_addr_q < DEPTH) ? RespOk : RespErr;
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= RespOk;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        bresp_d   = bresp_q;
        w_commit  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (AWVALID && AWREADY) begin
                    aw_held_d = 1'b1;
                    w_addr_d  = AWADDR;
                end
                if (WVALID && WREADY) begin
                    w_held_d = 1'b1;
                    w_data_d = WDATA[7:0];
                end
                // Counter starts on the edge that captures the later of AW and W.
                if (aw_held_d && w_held_d) begin
                    w_cnt_d   = WLoad;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 4'd0) begin
                    w_commit  = 1'b1;
                    bresp_d   = w_in_range ? RespOk : RespErr;
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            bresp_q   <= RespOk;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            bresp_q   <= bresp_d;
        end
    end

    // Contents survive reset; the AXI write is issued last so it wins a same-address clash.
    always_ff @(posedge ACLK) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (w_commit && w_in_range) begin
            mem[w_addr_q[AW-1:0]] <= w_data_q;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: vector table, directed corner sequences and
// randomized traffic against a byte-array reference model.
module tb_axi_mem_responder;

    localparam int unsigned DEPTH     = 512;
    localparam int unsigned READ_LAT  = 4;
    localparam int unsigned WRITE_LAT = 4;
    localparam int unsigned AW        = $clog2(DEPTH);

    logic          ACLK;
    logic          ARESET;
    logic          ARVALID;
    logic [31:0]   ARADDR;
    logic          ARREADY;
    logic          RVALID;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RREADY;
    logic          AWVALID;
    logic [31:0]   AWADDR;
    logic          AWREADY;
    logic          WVALID;
    logic [31:0]   WDATA;
    logic          WREADY;
    logic          BVALID;
    logic [1:0]    BRESP;
    logic          BREADY;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_wdata;
    logic [7:0]    bd_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] model_mem [DEPTH];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          awd;
        int          wd;
        int          chk_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[13];

    axi_mem_responder #(
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .ARVALID (ARVALID),
        .ARADDR  (ARADDR),
        .ARREADY (ARREADY),
        .RVALID  (RVALID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RREADY  (RREADY),
        .AWVALID (AWVALID),
        .AWADDR  (AWADDR),
        .AWREADY (AWREADY),
        .WVALID  (WVALID),
        .WDATA   (WDATA),
        .WREADY  (WREADY),
        .BVALID  (BVALID),
        .BRESP   (BRESP),
        .BREADY  (BREADY),
        .bd_we   (bd_we),
        .bd_addr (bd_addr),
        .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] r;
        longint      b;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b = longint'(a) + i;
            if (b < DEPTH) r[8*i +: 8] = model_mem[b];
        end
        return r;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return (a < DEPTH) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
        if (a < DEPTH) model_mem[a] = d[7:0];
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [7:0] d);
        @(negedge ACLK);
        bd_we = 1'b1; bd_addr = a[AW-1:0]; bd_wdata = d;
        @(negedge ACLK);
        bd_we = 1'b0;
        model_mem[a[AW-1:0]] = d;
    endtask

    task automatic bd_check(input string name, input logic [31:0] a, input logic [7:0] exp);
        @(negedge ACLK);
        bd_addr = a[AW-1:0];
        #1 chk(name, {24'd0, bd_rdata}, {24'd0, exp});
    endtask

    task automatic check_reset_outputs();
        chk("rst_arready", {31'd0, ARREADY}, 0);
        chk("rst_awready", {31'd0, AWREADY}, 0);
        chk("rst_wready",  {31'd0, WREADY}, 0);
        chk("rst_rvalid",  {31'd0, RVALID}, 0);
        chk("rst_bvalid",  {31'd0, BVALID}, 0);
        chk("rst_rdata",   RDATA, 0);
        chk("rst_rresp",   {30'd0, RRESP}, 0);
        chk("rst_bresp",   {30'd0, BRESP}, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        int hs_edge;
        int guard;
        @(negedge ACLK);
        RREADY  = (hold == 0);
        ARADDR  = addr;
        ARVALID = 1'b1;
        guard   = 0;
        while (!ARREADY && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        hs_edge = cyc + 1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        guard   = 0;
        while (!RVALID && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        chk("rvalid_seen", {31'd0, RVALID}, 1);
        chk("r_latency", cyc - hs_edge, READ_LAT);
        data = RDATA;
        resp = RRESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("r_hold_valid", {31'd0, RVALID}, 1);
            chk("r_hold_data", RDATA, data);
            chk("r_hold_resp", {30'd0, RRESP}, {30'd0, resp});
            chk("r_hold_arready", {31'd0, ARREADY}, 0);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("r_one_beat", {31'd0, RVALID}, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int awd,
                            input int wd, input int hold, output logic [1:0] resp);
        bit aw_done;
        bit w_done;
        int aw_edge;
        int w_edge;
        int later;
        int c;
        int guard;
        aw_done = 0; w_done = 0; aw_edge = 0; w_edge = 0; c = 0;
        BREADY = (hold == 0);
        while ((!aw_done || !w_done) && c < 60) begin
            @(negedge ACLK);
            if (!aw_done && c >= awd) begin
                AWADDR = addr; AWVALID = 1'b1;
                if (AWREADY) begin aw_done = 1; aw_edge = cyc + 1; end
            end
            if (!w_done && c >= wd) begin
                WDATA = data; WVALID = 1'b1;
                if (WREADY) begin w_done = 1; w_edge = cyc + 1; end
            end
            c++;
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        later   = (aw_edge > w_edge) ? aw_edge : w_edge;
        chk("w_ready_low", {30'd0, AWREADY, WREADY}, 0);
        guard = 0;
        while (!BVALID && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        chk("bvalid_seen", {31'd0, BVALID}, 1);
        chk("b_latency", cyc - later, WRITE_LAT);
        resp = BRESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("b_hold_valid", {31'd0, BVALID}, 1);
            chk("b_hold_resp", {30'd0, BRESP}, {30'd0, resp});
            chk("b_hold_ready", {30'd0, AWREADY, WREADY}, 0);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        chk("b_one_beat", {31'd0, BVALID}, 0);
        chk("w_ready_back", {30'd0, AWREADY, WREADY}, 3);
    endtask

    initial begin : main
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] rd;
        logic [31:0] old;
        logic [1:0]  resp;
        int          hold;
        int          e;
        int          r_edge;
        int          b_edge;
        bit          late_valid;

        ARESET = 1'b1; ARVALID = 0; ARADDR = 0; RREADY = 1; AWVALID = 0; AWADDR = 0;
        WVALID = 0; WDATA = 0; BREADY = 1; bd_we = 0; bd_addr = 0; bd_wdata = 0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs();
        ARESET = 1'b0;
        #1 chk("ready_after_rst", {29'd0, ARREADY, AWREADY, WREADY}, 3'b111);

        // Fill every byte so the model and the memory start identical.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge ACLK);
            bd_we = 1'b1; bd_addr = AW'(i); bd_wdata = 8'($urandom);
            model_mem[i] = bd_wdata;
        end
        @(negedge ACLK);
        bd_we = 1'b0;
        bd_write(0, 8'h11); bd_write(1, 8'h22); bd_write(2, 8'h33); bd_write(3, 8'h44);
        bd_write(4, 8'h55); bd_write(88, 8'h3C); bd_write(508, 8'h00);
        bd_write(509, 8'h9C); bd_write(510, 8'hB3); bd_write(511, 8'h7E);
        bd_check("bd_readback", 511, 8'h7E);

        vecs[0]  = '{0, 32'd0,          32'd0,    0, 0, 0,   32'h44332211, 2'b00};
        vecs[1]  = '{0, 32'd1,          32'd0,    0, 0, 0,   32'h55443322, 2'b00};
        vecs[2]  = '{0, 32'd509,        32'd0,    0, 0, 0,   32'h007EB39C, 2'b00};
        vecs[3]  = '{0, 32'd510,        32'd0,    0, 0, 0,   32'h00007EB3, 2'b00};
        vecs[4]  = '{0, 32'd511,        32'd0,    0, 0, 0,   32'h0000007E, 2'b00};
        vecs[5]  = '{0, 32'd512,        32'd0,    0, 0, 0,   32'h00000000, 2'b10};
        vecs[6]  = '{0, 32'hFFFF_FFFE,  32'd0,    0, 0, 0,   32'h00000000, 2'b10};
        vecs[7]  = '{1, 32'd508,        32'hA5,   2, 0, 508, 32'h000000A5, 2'b00};
        vecs[8]  = '{1, 32'd508,        32'hC3,   0, 2, 508, 32'h000000C3, 2'b00};
        vecs[9]  = '{1, 32'd508,        32'h96,   0, 0, 508, 32'h00000096, 2'b00};
        vecs[10] = '{1, 32'd600,        32'hFF,   0, 0, 88,  32'h0000003C, 2'b10};
        vecs[11] = '{1, 32'd512,        32'hEE,   1, 0, 0,   32'h00000011, 2'b10};
        vecs[12] = '{0, 32'd508,        32'd0,    0, 0, 0,   32'h7EB39C96, 2'b00};

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].awd, vecs[i].wd, 0, resp);
                model_wr(vecs[i].addr, vecs[i].wdata);
                chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
                bd_check($sformatf("vec%0d_byte", i), vecs[i].chk_addr, vecs[i].exp_data[7:0]);
            end else begin
                do_read(vecs[i].addr, 0, rd, resp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
            end
        end

        // Ten cycles of response backpressure on each channel.
        do_read(32'h40, 10, rd, resp);
        chk("bp_rdata", rd, model_rd(32'h40));
        do_write(32'h44, 32'h0000_0069, 1, 0, 10, resp);
        model_wr(32'h44, 32'h69);
        chk("bp_bresp", {30'd0, resp}, 0);
        bd_check("bp_byte", 32'h44, 8'h69);

        // Read sample and write commit on the same edge, same address.
        bd_write(8, 8'h11);
        old = model_rd(8);
        @(negedge ACLK);
        ARADDR = 8; ARVALID = 1; AWADDR = 8; AWVALID = 1; WDATA = 32'h5A; WVALID = 1;
        RREADY = 1; BREADY = 1;
        chk("col_ready", {29'd0, ARREADY, AWREADY, WREADY}, 3'b111);
        e = cyc + 1;
        @(negedge ACLK);
        ARVALID = 0; AWVALID = 0; WVALID = 0;
        r_edge = -1; b_edge = -1; rd = '0;
        for (int k = 0; k < 20; k++) begin
            if (RVALID && r_edge < 0) begin r_edge = cyc; rd = RDATA; end
            if (BVALID && b_edge < 0) b_edge = cyc;
            @(negedge ACLK);
        end
        chk("col_r_lat", r_edge - e, READ_LAT);
        chk("col_b_lat", b_edge - e, WRITE_LAT);
        chk("col_old_data", rd, old);
        model_wr(8, 32'h5A);
        do_read(8, 0, rd, resp);
        chk("col_new_data", rd, model_rd(8));
        chk("col_new_byte", {24'd0, rd[7:0]}, 32'h5A);

        // Reset while both channels are waiting out their latency.
        bd_write(20, 8'h77);
        @(negedge ACLK);
        ARADDR = 16; ARVALID = 1; AWADDR = 20; AWVALID = 1; WDATA = 32'h88; WVALID = 1;
        @(negedge ACLK);
        ARVALID = 0; AWVALID = 0; WVALID = 0;
        @(negedge ACLK);
        ARESET = 1'b1;
        #1 check_reset_outputs();
        @(negedge ACLK);
        ARESET = 1'b0;
        #1 chk("ready_after_midrst", {29'd0, ARREADY, AWREADY, WREADY}, 3'b111);
        late_valid = 0;
        repeat (12) begin
            @(negedge ACLK);
            if (RVALID || BVALID) late_valid = 1;
        end
        chk("no_resp_after_rst", {31'd0, late_valid}, 0);
        bd_check("midrst_byte", 20, 8'h77);
        do_read(16, 0, rd, resp);
        chk("post_rst_rdata", rd, model_rd(16));
        chk("post_rst_rresp", {30'd0, resp}, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            a    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 4));
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), hold, resp);
                model_wr(a, d);
                chk("rnd_bresp", {30'd0, resp}, {30'd0, model_resp(a)});
                if (a < DEPTH) bd_check("rnd_wbyte", a, model_mem[a[AW-1:0]]);
            end else begin
                do_read(a, hold, rd, resp);
                chk("rnd_rdata", rd, model_rd(a));
                chk("rnd_rresp", {30'd0, resp}, {30'd0, model_resp(a)});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
